// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit Green CPU pipeline.
//
// Contents:
//   WIDTH, REG_ADDR_W, CTRL_W : default datapath, register-index and
//                               ALU-control widths
//   alu_op_e                  : ALU operation encodings
//   REG_ZERO                  : index of the hardwired-zero register
package cpu_pkg;

  localparam int WIDTH      = 16;
  localparam int REG_ADDR_W = 3;
  localparam int CTRL_W     = 4;

  typedef enum logic [CTRL_W-1:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_SLT = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_AND = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_SLL = 4'b0110,
    ALU_SRA = 4'b0111
  } alu_op_e;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux for the ID/EX stage.
//
// Resolves one source operand. The EX/MEM candidate has priority over the
// MEM/WB candidate because it is the younger producer. Register 0 never
// forwards; it always returns the registered read data.
//
// Ports:
//   src       in  source register index held in ID/EX
//   reg_data  in  register-file value captured in ID/EX
//   mem_*     in  EX/MEM writeback candidate (valid, rd, data)
//   wb_*      in  MEM/WB writeback candidate (valid, rd, data)
//   value     out resolved operand
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int WIDTH      = cpu_pkg::WIDTH,
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic [WIDTH-1:0]      reg_data,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [WIDTH-1:0]      mem_data,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [WIDTH-1:0]      wb_data,
  output logic [WIDTH-1:0]      value
);

  logic src_nonzero;
  assign src_nonzero = (src != REG_ZERO);

  always_comb begin
    // NOTE: default assigned first so every path drives value; no latch.
    value = reg_data;
    if (src_nonzero && mem_valid && (mem_rd == src)) begin
      value = mem_data;
    end else if (src_nonzero && wb_valid && (wb_rd == src)) begin
      value = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 16-bit Green CPU.
//
// Captures decoded instructions, forwards MEM/WB results onto the ALU
// operands, and inserts a one-cycle bubble on a load-use hazard.
// Update priority per edge: rst > flush > ex_stall > load_use_stall > capture.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       decode handshake
//   id_*                      decoded instruction fields and control flags
//   flush                     kill the instruction being captured
//   ex_stall                  downstream cannot advance; hold all state
//   fwd_mem_* / fwd_wb_*      writeback candidates for forwarding
//   ex_*                      registered instruction toward the ALU
//   load_use_stall            bubble request to fetch/decode
//
// Build option:
//   GREEN_OPERAND_GATE_EN  when defined, ALU operands, store data and ALU
//                          control are forced to zero/ADD while ex_valid=0
//                          so bubbles cause no toggles on the ALU inputs.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH      = cpu_pkg::WIDTH,
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int CTRL_W     = cpu_pkg::CTRL_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [WIDTH-1:0]      id_rs1_data,
  input  logic [WIDTH-1:0]      id_rs2_data,
  input  logic [WIDTH-1:0]      id_imm,
  input  logic [CTRL_W-1:0]     id_alu_ctrl,
  input  logic                  id_alu_src,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  flush,
  input  logic                  ex_stall,
  input  logic                  fwd_mem_valid,
  input  logic [REG_ADDR_W-1:0] fwd_mem_rd,
  input  logic [WIDTH-1:0]      fwd_mem_data,
  input  logic                  fwd_wb_valid,
  input  logic [REG_ADDR_W-1:0] fwd_wb_rd,
  input  logic [WIDTH-1:0]      fwd_wb_data,
  output logic                  ex_valid,
  output logic [WIDTH-1:0]      ex_alu_a,
  output logic [WIDTH-1:0]      ex_alu_b,
  output logic [CTRL_W-1:0]     ex_alu_ctrl,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic [WIDTH-1:0]      ex_store_data,
  output logic                  load_use_stall
);

  logic                  valid_q;
  logic [REG_ADDR_W-1:0] rs1_q, rs2_q, rd_q;
  logic [WIDTH-1:0]      rs1_data_q, rs2_data_q, imm_q;
  logic [CTRL_W-1:0]     alu_ctrl_q;
  logic                  alu_src_q, reg_write_q, mem_read_q, mem_write_q;

  // Stores read rs2 even when operand b is the immediate.
  logic uses_rs2;
  assign uses_rs2 = !id_alu_src || id_mem_write;

  // Self-clearing: the bubble drops mem_read_q, so this lasts one cycle.
  assign load_use_stall = in_valid && valid_q && mem_read_q && (rd_q != REG_ZERO) &&
                          ((id_rs1 == rd_q) || (uses_rs2 && (id_rs2 == rd_q)));

  // flush does not drop in_ready: the killed slot is simply not kept.
  assign in_ready = !ex_stall && !load_use_stall;

  logic insert_bubble;
  assign insert_bubble = flush || (!ex_stall && load_use_stall);

  // NOTE: non-blocking assignments for all sequential state, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      alu_ctrl_q  <= ALU_ADD;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (insert_bubble) begin
      // Operand fields hold; only validity, flags and control are cleared.
      valid_q     <= 1'b0;
      alu_ctrl_q  <= ALU_ADD;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (!ex_stall) begin
      valid_q     <= in_valid;
      rs1_q       <= id_rs1;
      rs2_q       <= id_rs2;
      rd_q        <= id_rd;
      rs1_data_q  <= id_rs1_data;
      rs2_data_q  <= id_rs2_data;
      imm_q       <= id_imm;
      alu_ctrl_q  <= id_alu_ctrl;
      alu_src_q   <= id_alu_src;
      reg_write_q <= id_reg_write && in_valid;
      mem_read_q  <= id_mem_read  && in_valid;
      mem_write_q <= id_mem_write && in_valid;
    end
  end

  // Forwarding stays live during ex_stall so a retiring producer is seen.
  logic [WIDTH-1:0] rs1_fwd, rs2_fwd;

  fwd_mux #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .src       (rs1_q),
    .reg_data  (rs1_data_q),
    .mem_valid (fwd_mem_valid),
    .mem_rd    (fwd_mem_rd),
    .mem_data  (fwd_mem_data),
    .wb_valid  (fwd_wb_valid),
    .wb_rd     (fwd_wb_rd),
    .wb_data   (fwd_wb_data),
    .value     (rs1_fwd)
  );

  fwd_mux #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .src       (rs2_q),
    .reg_data  (rs2_data_q),
    .mem_valid (fwd_mem_valid),
    .mem_rd    (fwd_mem_rd),
    .mem_data  (fwd_mem_data),
    .wb_valid  (fwd_wb_valid),
    .wb_rd     (fwd_wb_rd),
    .wb_data   (fwd_wb_data),
    .value     (rs2_fwd)
  );

  assign ex_valid     = valid_q;
  assign ex_rd        = rd_q;
  assign ex_reg_write = reg_write_q && valid_q;
  assign ex_mem_read  = mem_read_q  && valid_q;
  assign ex_mem_write = mem_write_q && valid_q;

  always_comb begin
    ex_alu_a      = rs1_fwd;
    ex_alu_b      = alu_src_q ? imm_q : rs2_fwd;
    ex_store_data = rs2_fwd;
    ex_alu_ctrl   = alu_ctrl_q;
`ifdef GREEN_OPERAND_GATE_EN
    if (!valid_q) begin
      ex_alu_a      = '0;
      ex_alu_b      = '0;
      ex_store_data = '0;
      ex_alu_ctrl   = ALU_ADD;
    end
`endif
  end

endmodule
